// File: rtl/hs_parallel_in_pkg.sv
// Shared encodings for the handshaked parallel input port: FSM states,
// bus decode codes on {s_,ior_,iow_,a0} and the status bit position.
package hs_parallel_in_pkg;

   typedef enum logic [1:0] {
      S0 = 2'b00,
      S1 = 2'b01,
      S2 = 2'b10,
      S3 = 2'b11
   } state_t;

   localparam logic [3:0] DEC_STATUS = 4'b0010;
   localparam logic [3:0] DEC_RBR    = 4'b0011;
   localparam logic [3:0] DEC_CTRL   = 4'b0100;

   localparam int FI_BIT = 0;

endpackage

// File: rtl/hs_parallel_in_comb.sv
// CPU bus decode for the parallel input port. The control-write strobe only
// exists when HS_PARALLEL_IN_IRQ_EN is defined.
module hs_parallel_in_comb
   import hs_parallel_in_pkg::*;
(
   input  logic s_,
   input  logic ior_,
   input  logic iow_,
   input  logic a0,
   output logic e_s,
   output logic e_b
`ifdef HS_PARALLEL_IN_IRQ_EN
   ,
   output logic e_c
`endif
);

   logic [3:0] code;

   assign code = {s_, ior_, iow_, a0};
   assign e_s  = (code == DEC_STATUS);
   assign e_b  = (code == DEC_RBR);
`ifdef HS_PARALLEL_IN_IRQ_EN
   assign e_c  = (code == DEC_CTRL);
`endif

endmodule

// File: rtl/hs_parallel_in.sv
// Receiving end of the dav_/rfd byte handshake with a CPU-readable buffer.
// Optional interrupt enable and int_ output under HS_PARALLEL_IN_IRQ_EN.
//
// state | meaning
// s0    | idle, rfd=1, waiting for dav_ low
// s1    | byte latched, waiting for producer to release dav_
// s2    | byte available (FI=1), waiting for CPU RBR read
// s3    | read in progress, waiting for read strobe to end
module hs_parallel_in
   import hs_parallel_in_pkg::*;
(
   input  logic       clock,
   input  logic       reset_,
   input  logic       s_,
   input  logic       ior_,
   input  logic       iow_,
   input  logic       a0,
   inout  wire  [7:0] d7_d0,
   input  logic [7:0] byte_in,
   input  logic       dav_,
   output logic       rfd
`ifdef HS_PARALLEL_IN_IRQ_EN
   ,
   output logic       int_
`endif
);

   logic       e_s;
   logic       e_b;
   state_t     star;
   logic [7:0] rbr;
   logic       fi;
   logic [7:0] bus_data;

`ifdef HS_PARALLEL_IN_IRQ_EN
   logic       e_c;
   logic       ie;
`endif

   hs_parallel_in_comb u_comb (
      .s_   (s_),
      .ior_ (ior_),
      .iow_ (iow_),
      .a0   (a0),
      .e_s  (e_s),
      .e_b  (e_b)
`ifdef HS_PARALLEL_IN_IRQ_EN
      ,
      .e_c  (e_c)
`endif
   );

   always_ff @(posedge clock or negedge reset_) begin
      if (!reset_) begin
         star <= S0;
         rbr  <= 8'h00;
         fi   <= 1'b0;
         rfd  <= 1'b1;
      end else begin
         case (star)
            S0: begin
               rfd <= 1'b1;
               if (!dav_) begin
                  rbr  <= byte_in;
                  rfd  <= 1'b0;
                  star <= S1;
               end
            end
            S1: begin
               if (dav_) begin
                  fi   <= 1'b1;
                  star <= S2;
               end
            end
            S2: begin
               if (e_b) begin
                  star <= S3;
               end
            end
            S3: begin
               // The byte is only released once the CPU read strobe ends.
               if (!e_b) begin
                  fi   <= 1'b0;
                  rfd  <= 1'b1;
                  star <= S0;
               end
            end
            default: star <= S0;
         endcase
      end
   end

`ifdef HS_PARALLEL_IN_IRQ_EN
   always_ff @(posedge clock or negedge reset_) begin
      if (!reset_) begin
         ie <= 1'b0;
      end else if (e_c) begin
         ie <= d7_d0[0];
      end
   end

   assign int_ = ~(ie & fi);
`endif

   always_comb begin
      bus_data = 8'h00;
      if (e_b) begin
         bus_data = rbr;
      end else begin
         bus_data[FI_BIT] = fi;
      end
   end

   assign d7_d0 = (e_s | e_b) ? bus_data : 8'bz;

endmodule

// File: tb/tb_hs_parallel_in.sv
// Self-checking bench for hs_parallel_in: vector table, directed reset and
// handshake sequences, then random traffic against a protocol-level model.
`timescale 1ns/1ps
module tb_hs_parallel_in;

   localparam logic [3:0] C_IDLE = 4'b1111;
   localparam logic [3:0] C_STAT = 4'b0010;
   localparam logic [3:0] C_RBR  = 4'b0011;
   localparam logic [3:0] C_CTRL = 4'b0100;
   localparam logic [7:0] BUS_FLOAT = 8'hFF;

   typedef struct {
      logic [3:0] code;
      logic       dav;
      logic [7:0] b;
      logic [7:0] exp_bus;
      logic       exp_rfd;
   } vec_t;

   logic       clock;
   logic       reset_;
   logic       s_, ior_, iow_, a0;
   logic [7:0] byte_in;
   logic       dav_;
   logic       rfd;
   logic       int_;
   logic       tb_oe;
   logic [7:0] tb_drv;
   wire  [7:0] d7_d0;

   int compared;
   int mismatched;

   vec_t tbl [18];

   // Released bus floats high so an undriven bus is distinguishable.
   for (genvar gi = 0; gi < 8; gi++) begin : g_pu
      pullup (d7_d0[gi]);
   end

   assign d7_d0 = tb_oe ? tb_drv : 8'bz;

   hs_parallel_in dut (
      .clock   (clock),
      .reset_  (reset_),
      .s_      (s_),
      .ior_    (ior_),
      .iow_    (iow_),
      .a0      (a0),
      .d7_d0   (d7_d0),
      .byte_in (byte_in),
      .dav_    (dav_),
      .rfd     (rfd)
`ifdef HS_PARALLEL_IN_IRQ_EN
      ,
      .int_    (int_)
`endif
   );

`ifndef HS_PARALLEL_IN_IRQ_EN
   assign int_ = 1'b1;
`endif

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic apply(input logic [3:0] code, input logic dav, input logic [7:0] b);
      {s_, ior_, iow_, a0} = code;
      dav_    = dav;
      byte_in = b;
      #1;
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic ctrl_write(input logic [7:0] v);
      tb_drv = v;
      tb_oe  = 1'b1;
      apply(C_CTRL, 1'b1, 8'h00);
      tick();
      tb_oe  = 1'b0;
      apply(C_IDLE, 1'b1, 8'h00);
   endtask

   // Full transfer; starts and ends in idle with dav_ high.
   task automatic do_transfer(input logic [7:0] b, input logic exp_irq);
      apply(C_IDLE, 1'b0, b);
      check("xfer_rfd_idle", {7'b0, rfd}, 8'h01);
      tick();
      check("xfer_rfd_latched", {7'b0, rfd}, 8'h00);
      apply(C_IDLE, 1'b1, b);
      tick();
      apply(C_STAT, 1'b1, b);
      check("xfer_status_full", d7_d0, 8'h01);
      check("xfer_int_full", {7'b0, int_}, {7'b0, ~exp_irq});
      tick();
      apply(C_RBR, 1'b1, b);
      check("xfer_rbr", d7_d0, b);
      tick();
      apply(C_IDLE, 1'b1, b);
      check("xfer_rfd_reading", {7'b0, rfd}, 8'h00);
      tick();
      check("xfer_rfd_done", {7'b0, rfd}, 8'h01);
      check("xfer_int_done", {7'b0, int_}, 8'h01);
      apply(C_STAT, 1'b1, b);
      check("xfer_status_empty", d7_d0, 8'h00);
      apply(C_IDLE, 1'b1, b);
   endtask

   initial begin
      logic       m_busy, m_fi, m_read;
      logic [7:0] m_rbr;
      logic [3:0] code;
      logic       dv;
      logic [7:0] bv;
      logic [7:0] exp_bus;

      compared   = 0;
      mismatched = 0;
      tb_oe      = 1'b0;
      tb_drv     = 8'h00;
      reset_     = 1'b0;
      apply(C_IDLE, 1'b1, 8'h00);

      tbl[0]  = '{C_IDLE, 1'b0, 8'hA5, BUS_FLOAT, 1'b1};
      tbl[1]  = '{C_IDLE, 1'b0, 8'hA5, BUS_FLOAT, 1'b0};
      tbl[2]  = '{C_STAT, 1'b1, 8'hA5, 8'h00,     1'b0};
      tbl[3]  = '{C_STAT, 1'b1, 8'hA5, 8'h01,     1'b0};
      tbl[4]  = '{C_RBR,  1'b1, 8'hA5, 8'hA5,     1'b0};
      tbl[5]  = '{C_RBR,  1'b1, 8'hA5, 8'hA5,     1'b0};
      tbl[6]  = '{C_IDLE, 1'b1, 8'hA5, BUS_FLOAT, 1'b0};
      tbl[7]  = '{C_STAT, 1'b1, 8'hA5, 8'h00,     1'b1};
      tbl[8]  = '{C_RBR,  1'b0, 8'h11, 8'hA5,     1'b1};
      tbl[9]  = '{C_RBR,  1'b0, 8'h11, 8'h11,     1'b0};
      tbl[10] = '{C_STAT, 1'b0, 8'h11, 8'h00,     1'b0};
      tbl[11] = '{C_STAT, 1'b1, 8'h11, 8'h00,     1'b0};
      tbl[12] = '{C_IDLE, 1'b0, 8'h3C, BUS_FLOAT, 1'b0};
      tbl[13] = '{C_STAT, 1'b1, 8'h3C, 8'h01,     1'b0};
      tbl[14] = '{C_IDLE, 1'b0, 8'h3C, BUS_FLOAT, 1'b0};
      tbl[15] = '{C_RBR,  1'b1, 8'h3C, 8'h11,     1'b0};
      tbl[16] = '{C_IDLE, 1'b1, 8'h3C, BUS_FLOAT, 1'b0};
      tbl[17] = '{C_STAT, 1'b1, 8'h3C, 8'h00,     1'b1};

      // Reset state, checked while reset_ is still held low.
      #12;
      check("rst_rfd", {7'b0, rfd}, 8'h01);
      check("rst_bus_float", d7_d0, BUS_FLOAT);
      check("rst_int", {7'b0, int_}, 8'h01);
      apply(C_STAT, 1'b1, 8'h00);
      check("rst_status", d7_d0, 8'h00);
      apply(C_RBR, 1'b1, 8'h00);
      check("rst_rbr", d7_d0, 8'h00);
      apply(C_IDLE, 1'b1, 8'h00);
      reset_ = 1'b1;
      tick();

      for (int i = 0; i < 18; i++) begin
         apply(tbl[i].code, tbl[i].dav, tbl[i].b);
         check($sformatf("vec%0d_bus", i), d7_d0, tbl[i].exp_bus);
         check($sformatf("vec%0d_rfd", i), {7'b0, rfd}, {7'b0, tbl[i].exp_rfd});
         tick();
      end

      // Asynchronous reset while a byte waits for the CPU.
      apply(C_IDLE, 1'b0, 8'hC3);
      tick();
      apply(C_IDLE, 1'b1, 8'hC3);
      tick();
      apply(C_STAT, 1'b1, 8'hC3);
      check("mid_status_full", d7_d0, 8'h01);
      check("mid_rfd_busy", {7'b0, rfd}, 8'h00);
      #2;
      reset_ = 1'b0;
      #1;
      check("mid_rst_rfd", {7'b0, rfd}, 8'h01);
      check("mid_rst_status", d7_d0, 8'h00);
      apply(C_RBR, 1'b1, 8'hC3);
      check("mid_rst_rbr", d7_d0, 8'h00);
      apply(C_IDLE, 1'b1, 8'hC3);
      check("mid_rst_float", d7_d0, BUS_FLOAT);
      reset_ = 1'b1;
      tick();
      do_transfer(8'h5A, 1'b0);

`ifdef HS_PARALLEL_IN_IRQ_EN
      ctrl_write(8'h01);
      do_transfer(8'h77, 1'b1);
      ctrl_write(8'h00);
      do_transfer(8'h77, 1'b0);
`endif

      // Random traffic against a protocol-level model of the handshake.
      reset_ = 1'b0;
      #2;
      reset_ = 1'b1;
      tick();
      m_busy = 1'b0;
      m_fi   = 1'b0;
      m_read = 1'b0;
      m_rbr  = 8'h00;
      for (int n = 0; n < 1500; n++) begin
         case ($urandom_range(0, 3))
            0: code = C_RBR;
            1: code = C_STAT;
            2: code = C_IDLE;
            default: begin
               code = 4'($urandom_range(0, 15));
               if (code == C_CTRL) code = C_IDLE;
            end
         endcase
         dv = ($urandom_range(0, 2) != 0);
         bv = 8'($urandom);
         apply(code, dv, bv);
         if (code == C_STAT)     exp_bus = {7'b0, m_fi};
         else if (code == C_RBR) exp_bus = m_rbr;
         else                    exp_bus = BUS_FLOAT;
         check("rnd_bus", d7_d0, exp_bus);
         check("rnd_rfd", {7'b0, rfd}, {7'b0, ~m_busy});
         check("rnd_int", {7'b0, int_}, 8'h01);
         tick();
         if (!m_busy) begin
            if (!dv) begin
               m_busy = 1'b1;
               m_rbr  = bv;
            end
         end else if (!m_fi) begin
            if (dv) m_fi = 1'b1;
         end else if (!m_read) begin
            if (code == C_RBR) m_read = 1'b1;
         end else if (code != C_RBR) begin
            m_busy = 1'b0;
            m_fi   = 1'b0;
            m_read = 1'b0;
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
